// File: rtl/ad_ip_jesd204_tpl_dac_start_ctrl_pkg.sv
// Shared state encoding for the TPL DAC start/stop sequencer.
package ad_ip_jesd204_tpl_dac_start_ctrl_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_ARMED      = 3'd1;
  localparam logic [2:0] ST_SYNC       = 3'd2;
  localparam logic [2:0] ST_WAIT_READY = 3'd3;
  localparam logic [2:0] ST_RUN        = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE       = ST_IDLE,
    S_ARMED      = ST_ARMED,
    S_SYNC       = ST_SYNC,
    S_WAIT_READY = ST_WAIT_READY,
    S_RUN        = ST_RUN
  } state_t;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_trig_detect.sv
// Two-flop synchronizer for the external trigger level plus a rising-edge pulse.
module ad_ip_jesd204_tpl_dac_trig_detect (
  input  logic clk,
  input  logic rst,
  input  logic trig_in,
  output logic trig_pulse
);

  // [0],[1] synchronize; [2] holds the previous synchronized level
  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], trig_in};
    end
  end

  assign trig_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_start_ctrl.sv
// Arm/trigger/sync/run sequencer gating the DAC DMA valid path.
// Optional arm timeout is compiled in with DAC_START_CTRL_ARM_TIMEOUT_EN.
module ad_ip_jesd204_tpl_dac_start_ctrl
  import ad_ip_jesd204_tpl_dac_start_ctrl_pkg::*;
#(
  parameter int NUM_CHANNELS  = 2,
  parameter int COUNT_WIDTH   = 16,
  parameter int TIMEOUT_WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_arm,
  input  logic                     cfg_disarm,
  input  logic                     cfg_sw_trig,
  input  logic                     cfg_trig_en,
  input  logic [COUNT_WIDTH-1:0]   cfg_burst_len,
  input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
  input  logic                     ext_trig,
  input  logic [NUM_CHANNELS-1:0]  enable,
  input  logic                     link_ready,
  input  logic                     dac_dunf,
  output logic                     dac_sync,
  output logic [NUM_CHANNELS-1:0]  dac_valid,
  output logic                     run,
  output logic                     busy,
  output logic                     done,
  output logic                     dunf_sticky,
  output logic                     timeout_err
);

  state_t                 state;
  state_t                 state_next;
  logic [COUNT_WIDTH-1:0] beat_cnt;
  logic [COUNT_WIDTH-1:0] beat_inc;
  logic [COUNT_WIDTH-1:0] burst_len_q;
  logic                   ext_pulse;
  logic                   trig;
  logic                   last_beat;
  logic                   arm_accept;
  logic                   timeout_hit;

  ad_ip_jesd204_tpl_dac_trig_detect i_trig_detect (
    .clk        (clk),
    .rst        (rst),
    .trig_in    (ext_trig),
    .trig_pulse (ext_pulse)
  );

`ifdef DAC_START_CTRL_ARM_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
  logic [TIMEOUT_WIDTH-1:0] tmo_inc;

  assign tmo_inc     = tmo_cnt + TIMEOUT_WIDTH'(1);
  assign timeout_hit = (state == S_ARMED) && (cfg_timeout != '0) && (tmo_inc == cfg_timeout);

  // Counter sits at zero outside ARMED, so it starts cleared on entry
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmo_cnt <= (state == S_ARMED) ? tmo_inc : '0;
      if (arm_accept) begin
        timeout_err <= 1'b0;
      end else if (timeout_hit && !trig && !cfg_disarm) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^cfg_timeout;
  assign timeout_hit    = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  assign beat_inc  = beat_cnt + COUNT_WIDTH'(1);
  assign trig      = cfg_trig_en ? ext_pulse : cfg_sw_trig;
  assign last_beat = (state == S_RUN) && link_ready && (burst_len_q != '0) && (beat_inc == burst_len_q);

  always_comb begin
    state_next = state;
    arm_accept = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_arm) begin
          state_next = S_ARMED;
          arm_accept = 1'b1;
        end
      end
      S_ARMED: begin
        if (trig) begin
          state_next = S_SYNC;
        end else if (timeout_hit) begin
          state_next = S_IDLE;
        end
      end
      S_SYNC:       state_next = S_WAIT_READY;
      S_WAIT_READY: if (link_ready) state_next = S_RUN;
      S_RUN:        if (last_beat) state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
    // Abort beats every other event, including a same-cycle arm
    if (cfg_disarm) begin
      state_next = S_IDLE;
      arm_accept = 1'b0;
    end
  end

  assign dac_sync  = (state == S_SYNC);
  assign dac_valid = (state == S_RUN) ? (enable & {NUM_CHANNELS{link_ready}}) : '0;
  assign done      = last_beat && !cfg_disarm;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      run         <= 1'b0;
      busy        <= 1'b0;
      beat_cnt    <= '0;
      dunf_sticky <= 1'b0;
    end else begin
      state <= state_next;
      run   <= (state_next == S_RUN);
      busy  <= (state_next != S_IDLE);
      if (state == S_SYNC) begin
        beat_cnt <= '0;
      end else if ((state == S_RUN) && link_ready) begin
        beat_cnt <= beat_inc;
      end
      if (arm_accept) begin
        dunf_sticky <= 1'b0;
      end else if ((state == S_RUN) && dac_dunf) begin
        dunf_sticky <= 1'b1;
      end
    end
  end

  // Burst length is latched once per burst so mid-burst edits are ignored
  always_ff @(posedge clk) begin
    if (state == S_SYNC) begin
      burst_len_q <= cfg_burst_len;
    end
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_start_ctrl.sv
// Self-checking bench: directed table, hand sequences and randomized traffic vs a behavioural model.
module tb_ad_ip_jesd204_tpl_dac_start_ctrl;

  logic        clk = 1'b0;
  logic        rst, cfg_arm, cfg_disarm, cfg_sw_trig, cfg_trig_en;
  logic [15:0] cfg_burst_len;
  logic [23:0] cfg_timeout;
  logic        ext_trig, link_ready, dac_dunf;
  logic [1:0]  enable;
  logic        dac_sync, run, busy, done, dunf_sticky, timeout_err;
  logic [1:0]  dac_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_dac_start_ctrl #(
    .NUM_CHANNELS (2),
    .COUNT_WIDTH  (16),
    .TIMEOUT_WIDTH(24)
  ) dut (
    .clk(clk), .rst(rst), .cfg_arm(cfg_arm), .cfg_disarm(cfg_disarm),
    .cfg_sw_trig(cfg_sw_trig), .cfg_trig_en(cfg_trig_en), .cfg_burst_len(cfg_burst_len),
    .cfg_timeout(cfg_timeout), .ext_trig(ext_trig), .enable(enable),
    .link_ready(link_ready), .dac_dunf(dac_dunf), .dac_sync(dac_sync),
    .dac_valid(dac_valid), .run(run), .busy(busy), .done(done),
    .dunf_sticky(dunf_sticky), .timeout_err(timeout_err)
  );

  // Behavioural model: phase flags, a remaining-beats countdown and an ext_trig history queue
  bit   m_armed, m_sync, m_wait, m_run, m_finite, m_dunf, m_tmo;
  int   m_remaining, m_armed_cycles;
  logic hist[$];

  // Last observed outputs, for hand-written sequences
  logic       obs_sync, obs_run, obs_busy, obs_done, obs_dunf, obs_tmo;
  logic [1:0] obs_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    logic pulse, trig;
    pulse = hist[1] && !hist[2];
    trig  = cfg_trig_en ? pulse : cfg_sw_trig;
    hist.push_front(ext_trig);
    void'(hist.pop_back());
    if (rst) begin
      {m_armed, m_sync, m_wait, m_run, m_dunf, m_tmo} = '0;
      hist = '{1'b0, 1'b0, 1'b0};
      return;
    end
    if (m_run && dac_dunf) m_dunf = 1;
    if (cfg_disarm) begin
      {m_armed, m_sync, m_wait, m_run} = '0;
    end else if (m_armed) begin
      m_armed_cycles++;
      if (trig) begin
        m_armed = 0; m_sync = 1;
      end
`ifdef DAC_START_CTRL_ARM_TIMEOUT_EN
      else if (cfg_timeout != 0 && m_armed_cycles == int'(cfg_timeout)) begin
        m_armed = 0; m_tmo = 1;
      end
`endif
    end else if (m_sync) begin
      m_sync = 0; m_wait = 1;
      m_remaining = int'(cfg_burst_len);
      m_finite = (cfg_burst_len != 0);
    end else if (m_wait) begin
      if (link_ready) begin
        m_wait = 0; m_run = 1;
      end
    end else if (m_run) begin
      if (link_ready && m_finite) begin
        m_remaining--;
        if (m_remaining == 0) m_run = 0;
      end
    end else if (cfg_arm) begin
      m_armed = 1; m_dunf = 0; m_tmo = 0; m_armed_cycles = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    obs_sync = dac_sync; obs_valid = dac_valid; obs_run = run; obs_busy = busy;
    obs_done = done; obs_dunf = dunf_sticky; obs_tmo = timeout_err;
    chk("dac_sync", 32'(dac_sync), 32'(m_sync));
    chk("dac_valid", 32'(dac_valid), 32'(m_run ? (enable & {2{link_ready}}) : 2'b00));
    chk("run", 32'(run), 32'(m_run));
    chk("busy", 32'(busy), 32'(m_armed || m_sync || m_wait || m_run));
    chk("done", 32'(done), 32'(m_run && link_ready && m_finite && m_remaining == 1 && !cfg_disarm));
    chk("dunf_sticky", 32'(dunf_sticky), 32'(m_dunf));
    chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
    @(posedge clk);
    model_edge();
    #1;
    rst = 0; cfg_arm = 0; cfg_disarm = 0; cfg_sw_trig = 0;
  endtask

  // Arm, software-trigger and pass SYNC/WAIT_READY; returns with the DUT in RUN
  task automatic go_run(input logic [15:0] len);
    cfg_trig_en = 0; cfg_burst_len = len; link_ready = 1;
    cfg_arm = 1; tick();
    cfg_sw_trig = 1; tick();
    tick();
    tick();
  endtask

  typedef struct packed {
    logic arm, disarm, sw, link;
    logic [1:0] en;
    logic sync;
    logic [1:0] valid;
    logic run, busy, done;
  } vec_t;

  vec_t tbl[9];
  int   beats, found;

  initial begin
    // arm dis sw link en     sync valid  run busy done
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};

    rst = 1; cfg_arm = 0; cfg_disarm = 0; cfg_sw_trig = 0; cfg_trig_en = 0;
    cfg_burst_len = 0; cfg_timeout = 0; ext_trig = 0; enable = 2'b11;
    link_ready = 0; dac_dunf = 0;
    hist = '{1'b0, 1'b0, 1'b0};
    m_remaining = 0; m_armed_cycles = 0; m_finite = 0;
    {m_armed, m_sync, m_wait, m_run, m_dunf, m_tmo} = '0;
    @(posedge clk); model_edge(); #1;
    rst = 1; tick();

    // Reset state
    tick();
    chk("reset_outputs", 32'({obs_sync, obs_valid, obs_run, obs_busy, obs_done, obs_dunf, obs_tmo}), 32'd0);

    // Continuous stream, software trigger
    for (int i = 0; i < 9; i++) begin
      cfg_arm = tbl[i].arm; cfg_disarm = tbl[i].disarm; cfg_sw_trig = tbl[i].sw;
      link_ready = tbl[i].link; enable = tbl[i].en;
      tick();
      chk($sformatf("tbl%0d", i), 32'({obs_sync, obs_valid, obs_run, obs_busy, obs_done}),
          32'({tbl[i].sync, tbl[i].valid, tbl[i].run, tbl[i].busy, tbl[i].done}));
    end

    // Burst of 5 with gaps in link_ready
    enable = 2'b11;
    go_run(16'd5);
    beats = 0;
    foreach (tbl[k]) if (k < 7) begin
      link_ready = (k == 1 || k == 4) ? 1'b0 : 1'b1;
      cfg_burst_len = 16'd2;
      tick();
      if (obs_valid != 0) beats++;
      if (k == 6) chk("burst5_done_last", 32'(obs_done), 32'd1);
    end
    chk("burst5_beats", 32'(beats), 32'd5);
    link_ready = 1;
    tick();
    chk("burst5_busy_after", 32'(obs_busy), 32'd0);

    // External trigger: SYNC three edges after the rise
    cfg_trig_en = 1; cfg_arm = 1; tick();
    ext_trig = 1;
    found = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs_sync) begin found = i; break; end
    end
    chk("ext_trig_latency", 32'(found), 32'd3);
    cfg_disarm = 1; tick();
    ext_trig = 0; repeat (4) tick();
    ext_trig = 1;
    beats = 0;
    repeat (6) begin tick(); if (obs_busy || obs_sync) beats++; end
    chk("ext_trig_idle_ignored", 32'(beats), 32'd0);
    ext_trig = 0; repeat (3) tick();

    // Priority and sticky underflow
    go_run(16'd0);
    cfg_arm = 1; tick();
    tick();
    chk("arm_in_run_ignored", 32'(obs_run), 32'd1);
    cfg_arm = 1; cfg_disarm = 1; tick();
    tick();
    chk("disarm_beats_arm", 32'(obs_busy), 32'd0);
    dac_dunf = 1; tick(); dac_dunf = 0;
    chk("dunf_outside_run", 32'(dunf_sticky), 32'd0);
    go_run(16'd0);
    dac_dunf = 1; tick(); dac_dunf = 0;
    cfg_disarm = 1; tick();
    tick();
    chk("dunf_sticky_set", 32'(obs_dunf), 32'd1);
    cfg_arm = 1; tick();
    tick();
    chk("dunf_cleared_by_arm", 32'(obs_dunf), 32'd0);
    cfg_disarm = 1; tick();

    // Reset mid-RUN
    go_run(16'd0);
    rst = 1; tick();
    tick();
    chk("reset_mid_run", 32'({obs_sync, obs_valid, obs_run, obs_busy, obs_done}), 32'd0);

    // Single-beat burst
    go_run(16'd1);
    tick();
    chk("burst1_beat", 32'({obs_valid, obs_done}), 32'b111);
    tick();
    chk("burst1_idle", 32'({obs_valid, obs_busy}), 32'd0);

    // Arm timeout
    cfg_trig_en = 1; ext_trig = 0; cfg_timeout = 24'd10;
    cfg_arm = 1; tick();
`ifdef DAC_START_CTRL_ARM_TIMEOUT_EN
    beats = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!obs_busy) break;
      beats++;
    end
    chk("timeout_armed_cycles", 32'(beats), 32'd10);
    chk("timeout_err_set", 32'(obs_tmo), 32'd1);
`else
    repeat (15) tick();
    chk("no_timeout_armed_held", 32'(obs_busy), 32'd1);
    chk("no_timeout_err", 32'(obs_tmo), 32'd0);
`endif
    cfg_disarm = 1; tick();
    cfg_timeout = 24'd0;

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      cfg_arm      = ($urandom_range(0, 9) == 0);
      cfg_disarm   = ($urandom_range(0, 39) == 0);
      cfg_sw_trig  = ($urandom_range(0, 6) == 0);
      link_ready   = ($urandom_range(0, 9) < 7);
      dac_dunf     = ($urandom_range(0, 19) == 0);
      enable       = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) ext_trig = ~ext_trig;
      if ($urandom_range(0, 29) == 0) cfg_trig_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) cfg_burst_len = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) cfg_timeout = 24'($urandom_range(0, 15));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
